complete_cdb_arbiter: RTL and testbench

- Buffered, parametrised complete stage between the functional units and the ROB/CDB.
- Accepts up to NUM_FU results per cycle into per-FU FIFOs and grants up to CDB_WIDTH of them per cycle by round-robin.
- Drives registered CDB tag broadcasts and ROB completion packets.
- Applies ready/valid backpressure to FUs, and supports a squash (flush) on precise-state recovery.

---
 rtl/complete_cdb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_complete_cdb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complete_cdb_arbiter.sv
// complete_cdb_arbiter
//   Complete stage between the functional units and the ROB/CDB. Each FU
//   channel has a small result FIFO. Every cycle up to CDB_WIDTH FIFO heads
//   are granted round-robin (one per FU at most) and are presented on
//   registered CDB tag-broadcast and ROB completion ports on the next cycle.
//   flush squashes every buffered and outgoing result.
//
// Ports
//   clock, reset              clock, asynchronous active-high reset
//   flush                     synchronous squash of FIFOs, outputs and rr pointer
//   fu_valid / fu_ready       per-FU ready/valid handshake
//   fu_pr_idx, fu_rob_idx,    per-FU result fields, packed with FU i in slice i
//   fu_dest_value, fu_take_branch, fu_target_pc
//   cdb_valid, cdb_t_idx      per-port tag broadcast (suppressed for branches / tag 0)
//   rob_complete, rob_idx,    per-port ROB completion packet
//   rob_dest_value, rob_precise_state_enable, rob_target_pc, rob_pr_idx
module complete_cdb_arbiter #(
   parameter int unsigned NUM_FU    = 4,
   parameter int unsigned CDB_WIDTH = 2,
   parameter int unsigned BUF_DEPTH = 2,
   parameter int unsigned PR_IDX_W  = 6,
   parameter int unsigned ROB_IDX_W = 5,
   parameter int unsigned DATA_W    = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [NUM_FU-1:0]             fu_valid,
   output logic [NUM_FU-1:0]             fu_ready,
   input  logic [NUM_FU*PR_IDX_W-1:0]    fu_pr_idx,
   input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx,
   input  logic [NUM_FU*DATA_W-1:0]      fu_dest_value,
   input  logic [NUM_FU-1:0]             fu_take_branch,
   input  logic [NUM_FU*DATA_W-1:0]      fu_target_pc,
   output logic [CDB_WIDTH-1:0]          cdb_valid,
   output logic [CDB_WIDTH*PR_IDX_W-1:0] cdb_t_idx,
   output logic [CDB_WIDTH-1:0]          rob_complete,
   output logic [CDB_WIDTH*ROB_IDX_W-1:0] rob_idx,
   output logic [CDB_WIDTH*DATA_W-1:0]   rob_dest_value,
   output logic [CDB_WIDTH-1:0]          rob_precise_state_enable,
   output logic [CDB_WIDTH*DATA_W-1:0]   rob_target_pc,
   output logic [CDB_WIDTH*PR_IDX_W-1:0] rob_pr_idx
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   typedef struct packed {
      logic [PR_IDX_W-1:0]  pr;
      logic [ROB_IDX_W-1:0] rob;
      logic [DATA_W-1:0]    value;
      logic                 take_branch;
      logic [DATA_W-1:0]    target_pc;
   } entry_t;

   entry_t           mem   [NUM_FU][BUF_DEPTH];
   logic [PTR_W-1:0] head  [NUM_FU];
   logic [PTR_W-1:0] tail  [NUM_FU];
   logic [CNT_W-1:0] count [NUM_FU];
   logic [RR_W-1:0]  rr_ptr;

   logic [NUM_FU-1:0]    enq;
   logic [NUM_FU-1:0]    deq;
   entry_t               in_entry  [NUM_FU];
   logic [RR_W-1:0]      port_fu   [CDB_WIDTH];
   logic [CDB_WIDTH-1:0] port_used;
   entry_t               grant_e   [CDB_WIDTH];
   logic [RR_W-1:0]      rr_next;

   // Ready looks only at the registered count; a same-cycle dequeue does not help.
   always_comb begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         fu_ready[i] = (count[i] < CNT_W'(BUF_DEPTH));
         enq[i]      = fu_valid[i] && fu_ready[i] && !flush;
         in_entry[i] = '{pr:          fu_pr_idx[i*PR_IDX_W +: PR_IDX_W],
                         rob:         fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W],
                         value:       fu_dest_value[i*DATA_W +: DATA_W],
                         take_branch: fu_take_branch[i],
                         target_pc:   fu_target_pc[i*DATA_W +: DATA_W]};
      end
   end

   // Round-robin scan starting at rr_ptr; grants fill ports 0,1,... in scan order.
   always_comb begin
      int unsigned n;
      int unsigned idx;
      n         = 0;
      idx       = 0;
      deq       = '0;
      port_used = '0;
      rr_next   = rr_ptr;
      for (int unsigned p = 0; p < CDB_WIDTH; p++) port_fu[p] = '0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NUM_FU) idx = idx - NUM_FU;
         if (count[idx] != '0 && n < CDB_WIDTH) begin
            deq[idx]     = 1'b1;
            port_fu[n]   = RR_W'(idx);
            port_used[n] = 1'b1;
            n            = n + 1;
            rr_next      = (idx == NUM_FU - 1) ? '0 : RR_W'(idx + 1);
         end
      end
      for (int unsigned p = 0; p < CDB_WIDTH; p++)
         grant_e[p] = mem[port_fu[p]][head[port_fu[p]]];
   end

   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < NUM_FU; i++)
         if (enq[i]) mem[i][tail[i]] <= in_entry[i];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            head[i]  <= '0;
            tail[i]  <= '0;
            count[i] <= '0;
         end
         rr_ptr <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (flush) begin
               head[i]  <= '0;
               tail[i]  <= '0;
               count[i] <= '0;
            end else begin
               if (enq[i]) tail[i] <= tail[i] + PTR_W'(1);
               if (deq[i]) head[i] <= head[i] + PTR_W'(1);
               if (enq[i] && !deq[i])      count[i] <= count[i] + CNT_W'(1);
               else if (deq[i] && !enq[i]) count[i] <= count[i] - CNT_W'(1);
            end
         end
         rr_ptr <= flush ? '0 : rr_next;
      end
   end

   // Outputs default to zero every cycle; granted ports are filled unless flushing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cdb_valid                <= '0;
         cdb_t_idx                <= '0;
         rob_complete             <= '0;
         rob_idx                  <= '0;
         rob_dest_value           <= '0;
         rob_precise_state_enable <= '0;
         rob_target_pc            <= '0;
         rob_pr_idx               <= '0;
      end else begin
         cdb_valid                <= '0;
         cdb_t_idx                <= '0;
         rob_complete             <= '0;
         rob_idx                  <= '0;
         rob_dest_value           <= '0;
         rob_precise_state_enable <= '0;
         rob_target_pc            <= '0;
         rob_pr_idx               <= '0;
         if (!flush) begin
            for (int unsigned p = 0; p < CDB_WIDTH; p++) begin
               if (port_used[p]) begin
                  rob_complete[p]                          <= 1'b1;
                  rob_idx[p*ROB_IDX_W +: ROB_IDX_W]        <= grant_e[p].rob;
                  rob_dest_value[p*DATA_W +: DATA_W]       <= grant_e[p].value;
                  rob_precise_state_enable[p]              <= grant_e[p].take_branch;
                  rob_target_pc[p*DATA_W +: DATA_W]        <= grant_e[p].target_pc;
                  rob_pr_idx[p*PR_IDX_W +: PR_IDX_W]       <= grant_e[p].pr;
                  if (!grant_e[p].take_branch && grant_e[p].pr != '0) begin
                     cdb_valid[p]                          <= 1'b1;
                     cdb_t_idx[p*PR_IDX_W +: PR_IDX_W]     <= grant_e[p].pr;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_complete_cdb_arbiter.sv
module tb_complete_cdb_arbiter;

   localparam int NF = 4;
   localparam int CW = 2;
   localparam int BD = 2;
   localparam int PW = 6;
   localparam int RW = 5;
   localparam int DW = 32;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic [NF-1:0]    fu_valid = '0;
   logic [NF-1:0]    fu_ready;
   logic [NF*PW-1:0] fu_pr_idx = '0;
   logic [NF*RW-1:0] fu_rob_idx = '0;
   logic [NF*DW-1:0] fu_dest_value = '0;
   logic [NF-1:0]    fu_take_branch = '0;
   logic [NF*DW-1:0] fu_target_pc = '0;
   logic [CW-1:0]    cdb_valid;
   logic [CW*PW-1:0] cdb_t_idx;
   logic [CW-1:0]    rob_complete;
   logic [CW*RW-1:0] rob_idx;
   logic [CW*DW-1:0] rob_dest_value;
   logic [CW-1:0]    rob_precise_state_enable;
   logic [CW*DW-1:0] rob_target_pc;
   logic [CW*PW-1:0] rob_pr_idx;

   complete_cdb_arbiter #(
      .NUM_FU(NF), .CDB_WIDTH(CW), .BUF_DEPTH(BD),
      .PR_IDX_W(PW), .ROB_IDX_W(RW), .DATA_W(DW)
   ) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_pr_idx(fu_pr_idx),
      .fu_rob_idx(fu_rob_idx), .fu_dest_value(fu_dest_value),
      .fu_take_branch(fu_take_branch), .fu_target_pc(fu_target_pc),
      .cdb_valid(cdb_valid), .cdb_t_idx(cdb_t_idx),
      .rob_complete(rob_complete), .rob_idx(rob_idx),
      .rob_dest_value(rob_dest_value),
      .rob_precise_state_enable(rob_precise_state_enable),
      .rob_target_pc(rob_target_pc), .rob_pr_idx(rob_pr_idx)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [PW-1:0] pr;
      logic [RW-1:0] rob;
      logic [DW-1:0] val;
      logic          tb;
      logic [DW-1:0] tpc;
   } res_t;

   // Reference model: one queue per FU, round-robin pointer, expected output ports.
   res_t q [NF][$];
   int   rr;
   res_t exp_e [CW];
   bit   exp_v [CW];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NF; i++) q[i].delete();
      rr = 0;
      for (int p = 0; p < CW; p++) exp_v[p] = 0;
   endtask

   // Applies one clock edge worth of behaviour, using the pre-edge inputs.
   task automatic model_step();
      bit   pre_ready [NF];
      int   n, last, idx;
      res_t r;
      for (int i = 0; i < NF; i++) pre_ready[i] = (q[i].size() < BD);
      for (int p = 0; p < CW; p++) exp_v[p] = 0;
      if (flush) begin
         for (int i = 0; i < NF; i++) q[i].delete();
         rr = 0;
         return;
      end
      n = 0;
      last = -1;
      for (int k = 0; k < NF; k++) begin
         idx = (rr + k) % NF;
         if (q[idx].size() > 0 && n < CW) begin
            exp_e[n] = q[idx].pop_front();
            exp_v[n] = 1;
            n++;
            last = idx;
         end
      end
      if (last >= 0) rr = (last + 1) % NF;
      for (int i = 0; i < NF; i++) begin
         if (fu_valid[i] && pre_ready[i]) begin
            r.pr  = fu_pr_idx[i*PW +: PW];
            r.rob = fu_rob_idx[i*RW +: RW];
            r.val = fu_dest_value[i*DW +: DW];
            r.tb  = fu_take_branch[i];
            r.tpc = fu_target_pc[i*DW +: DW];
            q[i].push_back(r);
         end
      end
   endtask

   task automatic compare_all();
      logic [CW-1:0]    ec, ecv, epse;
      logic [CW*PW-1:0] ect, epr;
      logic [CW*RW-1:0] eri;
      logic [CW*DW-1:0] edv, etp;
      logic [NF-1:0]    erdy;
      ec = '0; ecv = '0; epse = '0; ect = '0; epr = '0; eri = '0; edv = '0; etp = '0;
      for (int p = 0; p < CW; p++) begin
         if (exp_v[p]) begin
            ec[p]            = 1'b1;
            eri[p*RW +: RW]  = exp_e[p].rob;
            edv[p*DW +: DW]  = exp_e[p].val;
            epse[p]          = exp_e[p].tb;
            etp[p*DW +: DW]  = exp_e[p].tpc;
            epr[p*PW +: PW]  = exp_e[p].pr;
            if (!exp_e[p].tb && exp_e[p].pr != 0) begin
               ecv[p]          = 1'b1;
               ect[p*PW +: PW] = exp_e[p].pr;
            end
         end
      end
      for (int i = 0; i < NF; i++) erdy[i] = (q[i].size() < BD);
      check("rob_complete", 128'(rob_complete), 128'(ec));
      check("cdb_valid", 128'(cdb_valid), 128'(ecv));
      check("cdb_t_idx", 128'(cdb_t_idx), 128'(ect));
      check("rob_idx", 128'(rob_idx), 128'(eri));
      check("rob_dest_value", 128'(rob_dest_value), 128'(edv));
      check("rob_pse", 128'(rob_precise_state_enable), 128'(epse));
      check("rob_target_pc", 128'(rob_target_pc), 128'(etp));
      check("rob_pr_idx", 128'(rob_pr_idx), 128'(epr));
      check("fu_ready", 128'(fu_ready), 128'(erdy));
   endtask

   // Inputs are set #1 after an edge; one call advances exactly one edge.
   task automatic cycle();
      for (int i = 0; i < NF; i++)
         if (fu_valid[i] && !flush) check("proto_ready", 128'(fu_ready[i]), 128'(1));
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      fu_valid = '0; fu_take_branch = '0; flush = 1'b0;
   endtask

   task automatic set_fu(input int i, input logic [PW-1:0] pr, input logic [RW-1:0] rob,
                         input logic [DW-1:0] val, input logic tb, input logic [DW-1:0] tpc);
      fu_valid[i]            = 1'b1;
      fu_pr_idx[i*PW +: PW]  = pr;
      fu_rob_idx[i*RW +: RW] = rob;
      fu_dest_value[i*DW +: DW] = val;
      fu_take_branch[i]      = tb;
      fu_target_pc[i*DW +: DW]  = tpc;
   endtask

   // Reset may be raised at any point of the cycle; outputs must clear without an edge.
   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #1;
      do_reset();

      // Single result, 2-edge latency
      set_fu(2, 6'd7, 5'd3, 32'hABCD, 1'b0, 32'h0);
      cycle();
      check("t1_no_bypass", 128'(rob_complete), 128'(0));
      check("t1_ready", 128'(fu_ready), 128'(4'hF));
      clear_inputs();
      cycle();
      check("t1_complete", 128'(rob_complete), 128'(2'b01));
      check("t1_rob_idx", 128'(rob_idx), 128'(10'd3));
      check("t1_cdb", 128'({cdb_valid, cdb_t_idx}), 128'({2'b01, 12'd7}));

      // Four simultaneous results over two ports
      do_reset();
      for (int i = 0; i < NF; i++) set_fu(i, PW'(i + 1), RW'(i + 10), DW'(i), 1'b0, 32'h0);
      cycle();
      clear_inputs();
      cycle();
      check("t2_first_pair", 128'(cdb_t_idx), 128'({6'd2, 6'd1}));
      cycle();
      check("t2_second_pair", 128'(cdb_t_idx), 128'({6'd4, 6'd3}));
      set_fu(0, 6'd5, 5'd1, 32'h5, 1'b0, 32'h0);
      set_fu(3, 6'd6, 5'd2, 32'h6, 1'b0, 32'h0);
      cycle();
      clear_inputs();
      cycle();
      check("t2_rr_wrapped", 128'(cdb_t_idx), 128'({6'd6, 6'd5}));

      // FU0 alone streaming: ready never drops
      do_reset();
      for (int c = 0; c < 8; c++) begin
         set_fu(0, PW'(c + 1), RW'(c), DW'(c), 1'b0, 32'h0);
         cycle();
         check("t3_fu0_ready", 128'(fu_ready[0]), 128'(1));
      end
      // All FUs saturating: ready is honoured, model checks order and no loss
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < NF; i++) begin
            if (q[i].size() < BD) set_fu(i, PW'($urandom_range(1, 63)), RW'($urandom), $urandom, 1'b0, $urandom);
            else fu_valid[i] = 1'b0;
         end
         cycle();
      end
      clear_inputs();
      for (int c = 0; c < 6; c++) cycle();

      // Branch result: no tag broadcast
      do_reset();
      set_fu(1, 6'd9, 5'd4, 32'h1234, 1'b1, 32'h100);
      cycle();
      clear_inputs();
      cycle();
      check("t4_pse", 128'(rob_precise_state_enable), 128'(2'b01));
      check("t4_tpc", 128'(rob_target_pc), 128'(64'h100));
      check("t4_pr", 128'(rob_pr_idx), 128'(12'd9));
      check("t4_cdb", 128'({cdb_valid, cdb_t_idx}), 128'(0));

      // Flush with buffered results and a same-cycle enqueue
      do_reset();
      for (int i = 0; i < NF; i++) set_fu(i, PW'(i + 20), RW'(i), DW'(i), 1'b0, 32'h0);
      cycle();
      clear_inputs();
      set_fu(0, 6'd30, 5'd9, 32'h9, 1'b0, 32'h0);
      cycle();
      set_fu(2, 6'd31, 5'd8, 32'h8, 1'b0, 32'h0);
      flush = 1'b1;
      cycle();
      check("t5_flush_out", 128'(rob_complete), 128'(0));
      check("t5_flush_ready", 128'(fu_ready), 128'(4'hF));
      clear_inputs();
      for (int c = 0; c < 4; c++) begin
         cycle();
         check("t5_nothing_after", 128'(rob_complete), 128'(0));
      end

      // Asynchronous reset mid-cycle with traffic in flight
      for (int i = 0; i < NF; i++) set_fu(i, PW'(i + 40), RW'(i), DW'(i), 1'b0, 32'h0);
      cycle();
      clear_inputs();
      cycle();
      check("t6_busy_before", 128'(rob_complete), 128'(2'b11));
      #2;
      do_reset();
      set_fu(3, 6'd12, 5'd7, 32'h77, 1'b0, 32'h0);
      cycle();
      clear_inputs();
      cycle();
      check("t6_latency", 128'(cdb_t_idx), 128'(12'd12));

      // Randomised traffic with occasional flushes
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NF; i++) begin
            if (q[i].size() < BD && $urandom_range(0, 99) < 55)
               set_fu(i, PW'($urandom_range(0, 63)), RW'($urandom), $urandom,
                      ($urandom_range(0, 3) == 0), $urandom);
            else fu_valid[i] = 1'b0;
         end
         flush = ($urandom_range(0, 39) == 0);
         cycle();
      end
      clear_inputs();
      for (int c = 0; c < 6; c++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
